// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential shift-add multiplier, one multiplier bit per cycle, unsigned or two's complement.
module shift_add_multiplier #(
  parameter int A_W = 12,
  parameter int B_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 signed_mode,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  output logic                 busy,
  output logic                 done,
  output logic [A_W+B_W-1:0]   p
);
  localparam int P_W = A_W + B_W;
  localparam int C_W = $clog2(B_W + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state;
  logic [P_W-1:0] acc, mcand, term, acc_nx;
  logic [B_W-1:0] mplier;
  logic [C_W-1:0] cnt;
  logic           sgn;
  assign busy = state == RUN;
  assign done = state == DONE;
  // The top multiplier bit carries negative weight in two's complement, so it is subtracted.
  always_comb begin
    term   = mplier[0] ? mcand : '0;
    acc_nx = (sgn && cnt == C_W'(1)) ? acc - term : acc + term;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      sgn    <= 1'b0;
      p      <= '0;
    end else if (clear) begin
      state <= IDLE;
    end else if (state != RUN && start) begin
      state  <= RUN;
      acc    <= '0;
      mcand  <= {{B_W{a[A_W-1] & signed_mode}}, a};
      mplier <= b;
      cnt    <= C_W'(B_W);
      sgn    <= signed_mode;
    end else if (state == RUN) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - C_W'(1);
      if (cnt == C_W'(1)) begin
        p     <= acc_nx;
        state <= DONE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed checks of a 12x4 and a 16x8 instance against an arithmetic reference model.
module tb_shift_add_multiplier;
  logic clk = 0, rst_n = 0;
  logic start = 0, clear = 0, sm = 0;
  logic [11:0] a = '0;
  logic [3:0]  b = '0;
  logic busy, done;
  logic [15:0] p;
  logic start2 = 0, clear2 = 0, sm2 = 0;
  logic [15:0] a2 = '0;
  logic [7:0]  b2 = '0;
  logic busy2, done2;
  logic [23:0] p2;
  int errors = 0, checks = 0, cyc = 0;
  int m_st = 0, m_rem = 0, m2_st = 0, m2_rem = 0;
  logic [15:0] m_p = '0, m_exp = '0;
  logic [23:0] m2_p = '0, m2_exp = '0;

  shift_add_multiplier #(.A_W(12), .B_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .signed_mode(sm),
    .a(a), .b(b), .busy(busy), .done(done), .p(p));
  shift_add_multiplier #(.A_W(16), .B_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .clear(clear2), .signed_mode(sm2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .p(p2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Exact product modulo 2^(xw+yw), operands interpreted per mode.
  function automatic logic [63:0] prod(input logic [31:0] x, input logic [31:0] y,
                                       input int xw, input int yw, input logic s);
    longint sx, sy, r;
    sx = longint'(x);
    sy = longint'(y);
    if (s) begin
      sx = (sx << (64 - xw)) >>> (64 - xw);
      sy = (sy << (64 - yw)) >>> (64 - yw);
    end
    r = sx * sy;
    return 64'(r) & ((64'd1 << (xw + yw)) - 64'd1);
  endfunction

  // Reference: an accepted start yields B_W busy cycles, then one done cycle with the exact product.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_rem = 0; m_p = '0;
    end else if (clear) m_st = 0;
    else if (m_st != 1 && start) begin
      m_st = 1; m_rem = 4; m_exp = 16'(prod(32'(a), 32'(b), 12, 4, sm));
    end else if (m_st == 1) begin
      m_rem--;
      if (m_rem == 0) begin m_st = 2; m_p = m_exp; end
    end else m_st = 0;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_st = 0; m2_rem = 0; m2_p = '0;
    end else if (clear2) m2_st = 0;
    else if (m2_st != 1 && start2) begin
      m2_st = 1; m2_rem = 8; m2_exp = 24'(prod(32'(a2), 32'(b2), 16, 8, sm2));
    end else if (m2_st == 1) begin
      m2_rem--;
      if (m2_rem == 0) begin m2_st = 2; m2_p = m2_exp; end
    end else m2_st = 0;
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_st == 1));
    chk("done", 64'(done), 64'(m_st == 2));
    chk("p", 64'(p), 64'(m_p));
    chk("busy_done_excl", 64'(busy & done), 64'd0);
    chk("busy2", 64'(busy2), 64'(m2_st == 1));
    chk("done2", 64'(done2), 64'(m2_st == 2));
    chk("p2", 64'(p2), 64'(m2_p));
  end

  task automatic run_op(input logic [11:0] ai, input logic [3:0] bi, input logic si, input logic [15:0] exp);
    int nb = 0;
    bit got = 0;
    a = ai; b = bi; sm = si; start = 1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      start = 0;
      if (busy) nb++;
      if (done) begin
        got = 1;
        chk("latency", 64'(nb), 64'd4);
        chk("product", 64'(p), 64'(exp));
      end
    end
    if (!got) chk("done_timeout", 64'd0, 64'd1);
  endtask

  logic [11:0] ta [4] = '{12'h00A, 12'h7FF, 12'h001, 12'hFFE};
  logic [3:0]  tb_ [4] = '{4'h3, 4'h7, 4'h8, 4'h2};
  logic        ts [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic [15:0] te [4] = '{16'h001E, 16'h37F9, 16'hFFF8, 16'hFFFC};

  initial begin
    int idx, last, n2;
    bit got;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_p", 64'(p), 64'd0);
    rst_n = 1;
    @(negedge clk);
    run_op(12'hFFF, 4'hF, 0, 16'hEFF1);
    @(negedge clk);
    run_op(12'h800, 4'h7, 1, 16'hC800);
    @(negedge clk);
    run_op(12'h123, 4'h0, 0, 16'h0000);
    @(negedge clk);
    run_op(12'hFFF, 4'hF, 1, 16'h0001);
    // clear in the second RUN cycle must leave the previous result intact
    @(negedge clk);
    a = 12'h555; b = 4'h5; sm = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    chk("clear_busy", 64'(busy), 64'd0);
    chk("clear_done", 64'(done), 64'd0);
    chk("clear_p", 64'(p), 64'h0001);
    repeat (6) @(negedge clk);
    clear = 1; start = 1;
    @(negedge clk);
    chk("clear_start_busy", 64'(busy), 64'd0);
    clear = 0; start = 0;
    // back-to-back with start held high, operands scrambled during RUN
    @(negedge clk);
    idx = 0; last = 0;
    a = ta[0]; b = tb_[0]; sm = ts[0]; start = 1;
    for (int i = 0; i < 40 && idx < 4; i++) begin
      @(negedge clk);
      if (done) begin
        chk("b2b_product", 64'(p), 64'(te[idx]));
        if (idx > 0) chk("b2b_interval", 64'(cyc - last), 64'd5);
        last = cyc;
        idx++;
        if (idx == 4) start = 0;
        else begin a = ta[idx]; b = tb_[idx]; sm = ts[idx]; end
      end else if (busy) begin
        a = 12'($urandom); b = 4'($urandom); sm = 1'($urandom);
      end
    end
    chk("b2b_count", 64'(idx), 64'd4);
    start = 0;
    // asynchronous reset between clock edges mid-RUN
    @(negedge clk);
    a = 12'hABC; b = 4'h9; sm = 0; start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_done", 64'(done), 64'd0);
    chk("async_rst_p", 64'(p), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    run_op(12'h003, 4'h5, 0, 16'h000F);
    // wider instance, random operands in both modes
    n2 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      a2 = (k == 3) ? 16'h0 : 16'($urandom);
      b2 = (k == 5) ? 8'h0 : 8'($urandom);
      sm2 = 1'(k);
      start2 = 1;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        start2 = 0;
        if (done2) begin got = 1; n2++; end
      end
      if (!got) chk("done2_timeout", 64'd0, 64'd1);
    end
    chk("wide_done_count", 64'(n2), 64'd20);
    @(negedge clk);
    a2 = 16'h8000; b2 = 8'h80; sm2 = 1; start2 = 1;
    @(negedge clk);
    start2 = 0;
    repeat (8) @(negedge clk);
    chk("wide_min_product", 64'(p2), 64'h400000);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have parameter A_W, default 12, multiplicand width in bits (legal values 2..32).
REQ-002 SHALL have parameter B_W, default 4, multiplier width in bits (legal values 2..32).
REQ-003 SHALL derive product width P_W = A_W + B_W internally; it SHALL NOT be a user-overridable parameter.
REQ-004 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, request to begin a multiply with the current a, b and signed_mode.
REQ-007 SHALL have port clear, input, 1, synchronous abort of an operation in progress.
REQ-008 SHALL have port signed_mode, input, 1; 0 treats a and b as unsigned, 1 treats them as two's complement.
REQ-009 SHALL have port a, input, A_W, multiplicand.
REQ-010 SHALL have port b, input, B_W, multiplier.
REQ-011 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-012 SHALL have port done, output, 1, single-cycle pulse marking that p holds a new result.
REQ-013 SHALL have port p, output, P_W, registered product.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 at a rising edge SHALL capture a, b and signed_mode, clear the accumulator, load the bit counter with B_W, and enter RUN.
REQ-016 start SHALL be ignored while in RUN, and a, b and signed_mode SHALL NOT be resampled during RUN.
REQ-017 Each RUN cycle SHALL consume one multiplier bit, LSB first: add the shifted multiplicand when the bit is 1, then shift and decrement the counter.
REQ-018 In signed mode, the multiplicand SHALL be sign-extended to P_W, and the partial product for multiplier bit B_W-1 SHALL be subtracted rather than added.
REQ-019 All arithmetic SHALL be modulo 2^P_W; the result SHALL be exact for all operand values in both modes.
REQ-020 Latency: with start accepted at edge E, the FSM SHALL be in RUN for exactly B_W cycles and SHALL enter DONE at edge E+B_W.
REQ-021 At edge E+B_W, p SHALL be loaded with the full product.
REQ-022 done SHALL be high for exactly the one cycle spent in DONE.
REQ-023 busy SHALL equal (state==RUN).
REQ-024 busy and done SHALL never be high together.
REQ-025 DONE SHALL return to IDLE at the next edge unless start=1, in which case it SHALL go directly to RUN, giving back-to-back throughput of one result per B_W+1 cycles.
REQ-026 p SHALL hold its value until the next completed operation, and SHALL NOT change during RUN.
REQ-027 clear=1 at an edge SHALL force IDLE from any state, leave p unchanged, and suppress done.
REQ-028 clear SHALL take priority over start at the same edge.
REQ-029 A zero operand SHALL NOT shorten latency; every operation SHALL take exactly B_W RUN cycles.

Reset
REQ-030 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, busy=0, done=0, p=0, and clear the counter and accumulator.
REQ-031 Reset asserted mid-RUN SHALL abandon the operation with no done pulse and p=0.
REQ-032 After rst_n rises, the first start SHALL be honoured at the first rising edge at which it is high.

Verification
REQ-033 Default parameters, unsigned, a=0xFFF, b=0xF, start for 1 cycle -> busy high 4 cycles, then done=1 for 1 cycle with p=0xEFF1.
REQ-034 Signed, a=0xFFF (-1), b=0xF (-1) -> p=0x0001; signed, a=0x800 (-2048), b=0x7 -> p=0xC800 (-14336).
REQ-035 Unsigned, a=0x123, b=0x0 -> done after exactly 4 RUN cycles with p=0x0000.
REQ-036 start held high continuously with new operands at each DONE cycle -> done every 5 cycles, and each p matches its operand pair; start pulses during RUN are ignored.
REQ-037 clear=1 in the 2nd RUN cycle after a prior result 0x0001 -> IDLE next cycle, no done, p stays 0x0001; clear and start together in IDLE -> stays IDLE.
REQ-038 rst_n low mid-RUN between clock edges -> busy=0 and p=0 immediately, no done; repeat with A_W=16, B_W=8 on random signed and unsigned operands against a reference model.
